// File: rtl/quadra_sched_pkg.sv
// Shared types and constants for the quadra scheduler and its datapath.
package quadra_sched_pkg;

    localparam int unsigned QUADRA_LAT = 3;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 16;
    localparam int unsigned TAG_MAX_W  = 3;   // wide enough for up to 8 requesters

    typedef logic                 ck_t;
    typedef logic                 rs_t;
    typedef logic                 dv_t;
    typedef logic [X_W-1:0]       x_t;
    typedef logic [Y_W-1:0]       y_t;
    typedef logic [TAG_MAX_W-1:0] tag_t;

    typedef struct packed {
        dv_t  vld;
        tag_t tag;
    } sched_slot_t;

endpackage

// File: rtl/quadra_rr_arb.sv
// Combinational round-robin arbiter: first eligible index at or above ptr, wrapping.
module quadra_rr_arb
    import quadra_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] elig,
    input  tag_t         ptr,
    output logic [N-1:0] grant,
    output tag_t         idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && i == j && elig[i]) begin
                    grant[i] = 1'b1;
                    idx      = tag_t'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quadra_sched.sv
// Shares one quadra pipeline between N requesters; tags steer each result back to its owner.
module quadra_sched
    import quadra_sched_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = QUADRA_LAT
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [N-1:0]          cfg_mask,
    input  logic [N-1:0][X_W-1:0] req_x,
    input  logic [N-1:0]          req_vld,
    output logic [N-1:0]          req_rdy,
    output logic [X_W-1:0]        q_x,
    output logic                  q_x_dv,
    input  logic [Y_W-1:0]        q_y,
    input  logic                  q_y_dv,
    output logic [Y_W-1:0]        rsp_y,
    output logic [N-1:0]          rsp_vld,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int unsigned TAG_W = $clog2(N);

    if (N < 2 || N > 8 || TAG_W > TAG_MAX_W) begin : g_bad_n
        $error("quadra_sched: N must be in 2..8");
    end

    logic [N-1:0]   elig;
    logic [N-1:0]   grant;
    tag_t           idx;
    tag_t           ptr;
    tag_t           tag_0;
    logic [X_W-1:0] sel_x;
    sched_slot_t    pipe [LAT];
    sched_slot_t    tail;
    logic           misalign;

    assign elig    = req_vld & cfg_mask;
    assign req_rdy = grant;

    quadra_rr_arb #(.N(N)) u_arb (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );

    always_comb begin
        sel_x = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) sel_x = req_x[i];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr    <= '0;
            q_x    <= '0;
            q_x_dv <= 1'b0;
            tag_0  <= '0;
        end else begin
            q_x_dv <= |grant;
            if (|grant) begin
                q_x   <= sel_x;
                tag_0 <= idx;
                ptr   <= (idx == tag_t'(N - 1)) ? '0 : idx + tag_t'(1);
            end
        end
    end

    // Tag pipe mirrors the datapath latency; it never stalls.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= '{vld: q_x_dv, tag: tag_0};
            for (int unsigned k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign tail     = pipe[LAT-1];
    assign misalign = (tail.vld != q_y_dv);
    assign rsp_y    = q_y;

    always_comb begin
        rsp_vld = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rsp_vld[i] = tail.vld & q_y_dv & (tail.tag == tag_t'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err <= 1'b0;
        end else if (misalign) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quadra_sched.sv
// Scoreboard bench for quadra_sched with a behavioural quadra datapath model.
module tb_quadra_sched;

    localparam int N   = 4;
    localparam int LAT = 3;

    typedef struct {
        int          owner;
        int unsigned y;
        int unsigned due;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_b = 1'b0;
    logic [N-1:0]        cfg_mask = '0;
    logic [N-1:0][7:0]   req_x = '0;
    logic [N-1:0]        req_vld = '0;
    logic [N-1:0]        req_rdy;
    logic [7:0]          q_x;
    logic                q_x_dv;
    logic [15:0]         q_y;
    logic                q_y_dv;
    logic [15:0]         rsp_y;
    logic [N-1:0]        rsp_vld;
    logic                err;
    logic                err_clr = 1'b0;
    logic                inj = 1'b0;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned cyc  = 0;
    exp_t        sb [$];
    int          mptr   = 0;
    int          last_g = -1;
    logic [7:0]  exp_qx = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quadra_sched #(.N(N), .LAT(LAT)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .cfg_mask (cfg_mask),
        .req_x    (req_x),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .q_x      (q_x),
        .q_x_dv   (q_x_dv),
        .q_y      (q_y),
        .q_y_dv   (q_y_dv),
        .rsp_y    (rsp_y),
        .rsp_vld  (rsp_vld),
        .err      (err),
        .err_clr  (err_clr)
    );

    function automatic int unsigned fq(input logic [7:0] x);
        int unsigned v;
        v = x;
        return v * v + 3;
    endfunction

    // Quadra datapath model: fixed LAT-cycle delay, not reset by rst_b.
    logic [LAT-1:0] mdv = '0;
    logic [15:0]    my [LAT];
    always @(posedge clk) begin
        mdv   <= {mdv[LAT-2:0], q_x_dv};
        my[0] <= 16'(fq(q_x));
        for (int k = 1; k < LAT; k++) my[k] <= my[k-1];
    end
    assign q_y    = my[LAT-1];
    assign q_y_dv = mdv[LAT-1] | inj;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++) begin
            if (e[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0][7:0] rx();
        logic [N-1:0][7:0] v;
        for (int i = 0; i < N; i++) v[i] = 8'($urandom);
        return v;
    endfunction

    task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] mask,
                         input logic [N-1:0][7:0] xs);
        int g;
        @(negedge clk);
        chk("q_x_dv", q_x_dv, (last_g >= 0) ? 1 : 0);
        chk("q_x", q_x, exp_qx);
        req_vld  = vld;
        cfg_mask = mask;
        req_x    = xs;
        #1;
        g = pick(vld & mask, mptr);
        chk("req_rdy", req_rdy, (g >= 0) ? (1 << g) : 0);
        last_g = g;
        if (g >= 0) begin
            exp_qx = xs[g];
            sb.push_back('{owner: g, y: fq(xs[g]), due: cyc + 1 + LAT});
            mptr = (g + 1) % N;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '1, rx());
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
        idle(1);
        chk("drain", sb.size(), 0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        req_vld = '0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_cleared", err, 0);
        last_g = -1;
    endtask

    // Monitor: every presented result is matched against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst_b) begin
            if (rsp_vld != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_vld, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_owner", rsp_vld, 1 << e.owner);
                    chk("rsp_y", rsp_y, e.y);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("rsp_missing", rsp_vld, 1 << sb[0].owner);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0][7:0] xs;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_q_x_dv", q_x_dv, 0);
        chk("rst_q_x", q_x, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_err", err, 0);
        rst_b = 1'b1;

        // Single requester 0 with x=5
        idle(3);
        xs = rx();
        xs[0] = 8'd5;
        drive(4'b0001, '1, xs);
        drain();

        // Reset with a sample in flight; the stale datapath result must flag err
        drive(4'b0100, '1, rx());
        idle(1);
        @(negedge clk);
        rst_b   = 1'b0;
        req_vld = '0;
        sb.delete();
        #1;
        chk("mid_rst_q_x_dv", q_x_dv, 0);
        chk("mid_rst_q_x", q_x, 0);
        chk("mid_rst_rsp_vld", rsp_vld, 0);
        chk("mid_rst_req_rdy", req_rdy, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst_b  = 1'b1;
        mptr   = 0;
        last_g = -1;
        exp_qx = '0;
        idle(3);
        chk("err_stale", err, 1);
        clear_err();

        // All requesters valid: 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) drive('1, '1, rx());
        drain();

        // Masked requesters 0 and 2 never granted
        for (int k = 0; k < 6; k++) drive('1, 4'b1010, rx());
        drain();

        // Pointer wrap from 3 to 0
        drive(4'b0100, '1, rx());
        drive(4'b1001, '1, rx());
        drive(4'b0001, '1, rx());
        drain();
        chk("err_clean_dir", err, 0);

        // Result with empty tag pipe, then set-wins-over-clear, then clear
        @(negedge clk);
        req_vld = '0;
        inj = 1'b1;
        #1;
        chk("inj_rsp_vld", rsp_vld, 0);
        @(negedge clk);
        inj = 1'b0;
        #1;
        chk("err_inj", err, 1);
        @(negedge clk);
        inj = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        #1;
        chk("err_set_wins", err, 1);
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_clr", err, 0);
        last_g = -1;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] m;
            m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            drive(N'($urandom), m, rx());
        end
        drain();
        chk("err_clean_rand", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
